b2d_conv_sched: RTL
===================

// Module: b2d_conv_sched
// PURPOSE
//   Shared, sequential binary-to-BCD conversion engine with a round-robin arbiter.
//   Several clients (PC display, cycle counter, syscall output) request decimal
//   conversion of a WIDTH-bit value. The block grants one client at a time and runs
//   shift-and-add-3 (double dabble), one bit per clock. It then returns a latched BCD
//   result tagged with the client id, which feeds the seven-segment display path.
// PARAMETERS
//   NREQ    3   number of requesting clients (2..8)
//   WIDTH   12  binary operand width in bits
//   DIGITS  4   BCD digits produced (result width DIGITS*4)
// PORTS
//   clk       in   1             system clock, rising edge
//   rst_n     in   1             asynchronous active-low reset
//   req       in   NREQ          per-client request level; held until granted
//   req_data  in   NREQ*WIDTH    client i operand at [i*WIDTH +: WIDTH]
//   grant     out  NREQ          one-hot, 1-cycle pulse: request accepted, data sampled
//   busy      out  1             high from the cycle after grant until the done cycle, inclusive
//   done      out  1             1-cycle pulse: bcd_out/done_id/overflow valid
//   done_id   out  $clog2(NREQ)  index of the client whose result is in bcd_out
//   bcd_out   out  DIGITS*4      packed BCD result, most significant digit at top
//   overflow  out  1             operand >= 10**DIGITS; bcd_out holds the low DIGITS digits
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, grant=0, busy=0, done=0, done_id=0,
//     bcd_out=0, overflow=0, round-robin pointer=0, shift counter=0.
//   FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE:
//     - If any req bit is set, pick the first set bit searching from ptr, ptr+1, ...
//       with wrap modulo NREQ.
//     - Pulse grant[k] in that same cycle.
//     - Capture req_data[k] into the operand register and k into the id register.
//     - Clear the digit working register and overflow accumulator; cnt=0; go to SHIFT.
//     - No request: stay in IDLE, all outputs hold.
//   SHIFT, one iteration per cycle:
//     - Every digit >= 5 gets +3 (all digits corrected in parallel, from
//       pre-shift values).
//     - Then shift {digits, operand} left by 1.
//     - A 1 shifted out of the top digit sets the sticky overflow bit.
//     - cnt increments; after the WIDTH-th shift (cnt==WIDTH-1) go to DONE.
//   DONE (one cycle):
//     - bcd_out <= digits; done_id <= id; overflow <= sticky; done=1.
//     - ptr <= id+1 (mod NREQ); go to IDLE.
//     - A new grant is possible in the next cycle.
//   Latency: grant at cycle T -> done at T+WIDTH+1. Minimum spacing between
//     grants is WIDTH+2 cycles.
//   Requests while busy are not sampled; they wait. grant is never asserted
//     outside IDLE.
//   A req dropped before its grant is ignored; no state is kept per client.
//   req_data changes after grant do not affect the running conversion.
//   bcd_out, done_id and overflow hold their values between done pulses.
//   Reset mid-conversion: abort immediately to reset values. No done is
//     produced for the aborted job.
//   Overflow is impossible when 2**WIDTH <= 10**DIGITS; the logic still exists.
//   Only one of grant/done is high in any cycle (IDLE vs DONE are exclusive).
// TESTING
//   1. NREQ=3: req=3'b001, data0=12'd999.
//      -> grant=001 at T; busy T+1..T+13; done at T+13;
//         bcd_out=16'h0999, done_id=0, overflow=0.
//   2. data0=12'd4095 -> bcd_out=16'h4095.
//      data0=12'd0 -> bcd_out=16'h0000, done after 13 cycles.
//   3. req=3'b111 held continuously, data i = 100*(i+1).
//      -> grant order 0,1,2,0; done_id 0,1,2,0;
//         bcd_out 0100, 0200, 0300, 0100; grants exactly 14 cycles apart.
//   4. req=3'b100 arrives during client 0's conversion; req0 stays high.
//      -> after done(0), client 2 is granted before client 0.
//   5. Pull rst_n low 5 cycles after grant, release 2 cycles later.
//      -> all outputs 0 at once; no done pulse; next req on client 1 converts correctly.
//   6. WIDTH=14, DIGITS=4: operand 9999 -> bcd_out=16'h9999, overflow=0;
//      operand 10000 -> bcd_out=16'h0000, overflow=1.

Source files
------------

// File: rtl/b2d_conv_sched.sv
// Shared binary-to-BCD converter: round-robin grant among NREQ clients, then
// double dabble one bit per clock, returning a tagged, latched BCD result.
module b2d_conv_sched #(
  parameter int NREQ   = 3,
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4,
  localparam int IDW   = $clog2(NREQ),
  localparam int DW    = DIGITS * 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [DW-1:0]         bcd_out,
  output logic                  overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [IDW-1:0]     r_ptr, r_id, r_doneId, w_pick, w_ptrNext;
  logic [WIDTH-1:0]   r_opnd, w_opndSh;
  logic [DW-1:0]      r_digits, r_bcd, w_corr, w_digitsSh;
  logic [CW-1:0]      r_cnt;
  logic               r_sticky, r_ovf, w_found, w_carry, w_lastShift;
  logic [NREQ-1:0]    w_grant;

  // Round-robin search starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx     = 0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_pick  = IDW'(idx);
      end
    end
  end

  // Add-3 correction on pre-shift digits, then one combined left shift.
  always_comb begin
    w_corr = r_digits;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_digits[d*4 +: 4] >= 4'd5) w_corr[d*4 +: 4] = r_digits[d*4 +: 4] + 4'd3;
    end
    {w_carry, w_digitsSh, w_opndSh} = {w_corr, r_opnd, 1'b0};
  end

  assign w_lastShift = (r_cnt == CW'(WIDTH - 1));
  assign w_ptrNext   = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);

  always_comb begin
    w_next  = r_state;
    w_grant = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
          w_next  = S_SHIFT;
        end
      end
      S_SHIFT: if (w_lastShift) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Results are latched on the final shift so they are valid during the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_id     <= '0;
      r_opnd   <= '0;
      r_digits <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_bcd    <= '0;
      r_doneId <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_opnd   <= req_data[int'(w_pick)*WIDTH +: WIDTH];
            r_id     <= w_pick;
            r_digits <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          r_digits <= w_digitsSh;
          r_opnd   <= w_opndSh;
          r_sticky <= r_sticky | w_carry;
          r_cnt    <= r_cnt + CW'(1);
          if (w_lastShift) begin
            r_bcd    <= w_digitsSh;
            r_ovf    <= r_sticky | w_carry;
            r_doneId <= r_id;
          end
        end
        S_DONE:  r_ptr <= w_ptrNext;
        default: ;
      endcase
    end
  end

  assign grant    = w_grant;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign done_id  = r_doneId;
  assign bcd_out  = r_bcd;
  assign overflow = r_ovf;

endmodule
